// File: rtl/rr_stage_arbiter.sv
// Round-robin arbiter sharing one registered valid/stall pipeline stage between NREQ producers.
// Define ARB_BURST_EN to let a winner keep the grant for up to BURST_LEN consecutive beats.
module rr_stage_arbiter #(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           v_i,
    input  logic [NREQ*DATA_W-1:0]    data_i,
    output logic [NREQ-1:0]           stall_o,
    output logic                      v_o,
    output logic [DATA_W-1:0]         data_o,
    output logic [$clog2(NREQ)-1:0]   gid_o,
    input  logic                      stall_i
);

    localparam int unsigned ID_W = $clog2(NREQ);
    localparam logic [ID_W-1:0] LastId = ID_W'(NREQ - 1);

    if (NREQ < 2 || BURST_LEN < 1) begin : g_bad_cfg
        $error("rr_stage_arbiter: NREQ must be >= 2 and BURST_LEN >= 1");
    end

    function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] id);
        return (id == LastId) ? '0 : id + 1'b1;
    endfunction

    logic              v_q, v_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ID_W-1:0]   gid_q, gid_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;

    logic              load_en;
    logic              any_v;
    logic [ID_W-1:0]   grant_id;
    logic [DATA_W-1:0] grant_data;

    assign load_en = !v_q || !stall_i;
    assign any_v   = |v_i;

    // Scan from the highest offset down so the requester closest to ptr wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx      = '0;
        grant_id = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            idx = ID_W'((int'(ptr_q) + i) % int'(NREQ));
            if (v_i[idx]) begin
                grant_id = idx;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (grant_id == ID_W'(k)) begin
                grant_data = data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        stall_o = '1;
        for (int k = 0; k < int'(NREQ); k++) begin
            stall_o[k] = !(load_en && any_v && (grant_id == ID_W'(k)));
        end
    end

`ifdef ARB_BURST_EN
    localparam int unsigned BCNT_W = $clog2(BURST_LEN + 1);

    logic              lock_q, lock_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [BCNT_W-1:0] beat_cnt;

    // While locked, ptr_q names the burst owner, so the scan keeps picking it while it is valid.
    always_comb begin
        v_d      = v_q;
        data_d   = data_q;
        gid_d    = gid_q;
        ptr_d    = ptr_q;
        lock_d   = lock_q;
        bcnt_d   = bcnt_q;
        beat_cnt = '0;
        if (load_en) begin
            v_d = any_v;
            if (any_v) begin
                data_d   = grant_data;
                gid_d    = grant_id;
                beat_cnt = (lock_q && grant_id == ptr_q) ? bcnt_q + 1'b1 : BCNT_W'(1);
                if (beat_cnt >= BCNT_W'(BURST_LEN)) begin
                    ptr_d  = inc_id(grant_id);
                    bcnt_d = '0;
                    lock_d = 1'b0;
                end else begin
                    ptr_d  = grant_id;
                    bcnt_d = beat_cnt;
                    lock_d = 1'b1;
                end
            end else if (lock_q) begin
                ptr_d  = inc_id(ptr_q);
                bcnt_d = '0;
                lock_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q <= 1'b0;
            bcnt_q <= '0;
        end else begin
            lock_q <= lock_d;
            bcnt_q <= bcnt_d;
        end
    end
`else
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        gid_d  = gid_q;
        ptr_d  = ptr_q;
        if (load_en) begin
            v_d = any_v;
            if (any_v) begin
                data_d = grant_data;
                gid_d  = grant_id;
                ptr_d  = inc_id(grant_id);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q    <= 1'b0;
            data_q <= '0;
            gid_q  <= '0;
            ptr_q  <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            gid_q  <= gid_d;
            ptr_q  <= ptr_d;
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;
    assign gid_o  = gid_q;

endmodule

// File: tb/tb_rr_stage_arbiter.sv
// Self-checking bench for rr_stage_arbiter: constant vector table, corner-case sequences,
// and randomized traffic against a queue-free round-robin reference model.
module tb_rr_stage_arbiter;

    localparam int NREQ      = 2;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 4;
`ifdef ARB_BURST_EN
    localparam int BLEN = BURST_LEN;
`else
    localparam int BLEN = 1;
`endif

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [NREQ-1:0]        v_i;
    logic [NREQ*DATA_W-1:0] data_i;
    logic [NREQ-1:0]        stall_o;
    logic                   v_o;
    logic [DATA_W-1:0]      data_o;
    logic                   gid_o;
    logic                   stall_i;

    always #5 clk = ~clk;

    rr_stage_arbiter #(
        .NREQ      (NREQ),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .v_i     (v_i),
        .data_i  (data_i),
        .stall_o (stall_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .gid_o   (gid_o),
        .stall_i (stall_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who is next in line, and who (if anyone) owns an open burst.
    bit          m_vo;
    logic [31:0] m_data;
    int          m_gid, m_ptr, m_owner, m_cnt;

    task automatic model_reset();
        m_vo = 0; m_data = 0; m_gid = 0; m_ptr = 0; m_owner = -1; m_cnt = 0;
    endtask

    function automatic int model_winner();
        for (int o = 0; o < NREQ; o++) begin
            int k;
            k = (m_ptr + o) % NREQ;
            if (v_i[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_stall();
        logic [NREQ-1:0] s;
        int g;
        s = '1;
        g = model_winner();
        if ((!m_vo || !stall_i) && g >= 0) s[g] = 1'b0;
        return s;
    endfunction

    task automatic model_edge();
        int g;
        if (m_vo && stall_i) return;
        g = model_winner();
        if (g >= 0) begin
            m_vo   = 1;
            m_data = data_i[g*DATA_W +: DATA_W];
            m_gid  = g;
            m_cnt  = (m_owner == g) ? m_cnt + 1 : 1;
            if (m_cnt >= BLEN) begin
                m_owner = -1; m_cnt = 0; m_ptr = (g + 1) % NREQ;
            end else begin
                m_owner = g; m_ptr = g;
            end
        end else begin
            m_vo = 0;
            if (m_owner >= 0) begin
                m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_cnt = 0;
            end
        end
    endtask

    task automatic step_model();
        #1;
        chk("rand stall_o", 32'(stall_o), 32'(model_stall()));
        @(posedge clk);
        model_edge();
        #1;
        chk("rand v_o", 32'(v_o), 32'(m_vo));
        chk("rand data_o", data_o, m_data);
        chk("rand gid_o", 32'(gid_o), 32'(m_gid));
        @(negedge clk);
    endtask

    task automatic step_exp(input string name, input logic [1:0] v, input logic [31:0] d0,
                            input logic [31:0] d1, input logic st, input logic [1:0] es,
                            input logic evo, input logic [31:0] edata, input logic egid);
        v_i = v; data_i = {d1, d0}; stall_i = st;
        #1;
        chk({name, " stall_o"}, 32'(stall_o), 32'(es));
        @(posedge clk);
        #1;
        chk({name, " v_o"}, 32'(v_o), 32'(evo));
        chk({name, " data_o"}, data_o, edata);
        chk({name, " gid_o"}, 32'(gid_o), 32'(egid));
        @(negedge clk);
    endtask

    task automatic do_reset();
        v_i = '0; data_i = '0; stall_i = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [31:0] d0, d1;
        logic        st;
        logic [1:0]  es;
        logic        evo;
        logic [31:0] edata;
        logic        egid;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [1:0]  r4_es;
        logic [31:0] r4_data;
        logic        r4_gid;
`ifdef ARB_BURST_EN
        r4_es = 2'b10; r4_data = 32'd1; r4_gid = 1'b0;
`else
        r4_es = 2'b01; r4_data = 32'd2; r4_gid = 1'b1;
`endif
        // single beat, three stalled cycles, release, idle, bubble fill under stall, drain
        tbl[0] = '{2'b01, 32'd100, 32'd0,   1'b0, 2'b10, 1'b1, 32'd100, 1'b0};
        tbl[1] = '{2'b11, 32'd1,   32'd2,   1'b1, 2'b11, 1'b1, 32'd100, 1'b0};
        tbl[2] = '{2'b11, 32'd1,   32'd2,   1'b1, 2'b11, 1'b1, 32'd100, 1'b0};
        tbl[3] = '{2'b11, 32'd1,   32'd2,   1'b1, 2'b11, 1'b1, 32'd100, 1'b0};
        tbl[4] = '{2'b11, 32'd1,   32'd2,   1'b0, r4_es, 1'b1, r4_data, r4_gid};
        tbl[5] = '{2'b00, 32'd0,   32'd0,   1'b0, 2'b11, 1'b0, r4_data, r4_gid};
        tbl[6] = '{2'b10, 32'd0,   32'd200, 1'b1, 2'b01, 1'b1, 32'd200, 1'b1};
        tbl[7] = '{2'b00, 32'd0,   32'd0,   1'b1, 2'b11, 1'b1, 32'd200, 1'b1};
        tbl[8] = '{2'b00, 32'd0,   32'd0,   1'b0, 2'b11, 1'b0, 32'd200, 1'b1};

        v_i = '0; data_i = '0; stall_i = 1'b0;
        #1;
        chk("reset v_o", 32'(v_o), 32'd0);
        chk("reset data_o", data_o, 32'd0);
        chk("reset gid_o", 32'(gid_o), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            step_exp($sformatf("vec%0d", i), tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].st,
                     tbl[i].es, tbl[i].evo, tbl[i].edata, tbl[i].egid);
        end

        // Contention: both valid forever.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic g;
            g = 1'((i / BLEN) % 2);
            step_exp("contention", 2'b11, 32'hF, 32'hF, 1'b0, g ? 2'b01 : 2'b10,
                     1'b1, 32'hF, g);
        end

        // Asynchronous reset mid-stream, between clock edges.
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async reset v_o", 32'(v_o), 32'd0);
        chk("async reset data_o", data_o, 32'd0);
        chk("async reset gid_o", 32'(gid_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step_exp("post-reset", 2'b11, 32'd5, 32'd6, 1'b0, 2'b10, 1'b1, 32'd5, 1'b0);

`ifdef ARB_BURST_EN
        do_reset();
        step_exp("burst drop 0", 2'b11, 32'd7, 32'd8, 1'b0, 2'b10, 1'b1, 32'd7, 1'b0);
        step_exp("burst drop 1", 2'b11, 32'd7, 32'd8, 1'b0, 2'b10, 1'b1, 32'd7, 1'b0);
        step_exp("burst drop 2", 2'b10, 32'd7, 32'd8, 1'b0, 2'b01, 1'b1, 32'd8, 1'b1);
`endif

        do_reset();
        for (int n = 0; n < 600; n++) begin
            v_i     = 2'($urandom);
            data_i  = {$urandom, $urandom};
            stall_i = ($urandom_range(2) == 0);
            step_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
